fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//  Instruction prefetch queue between the fetch unit (PC, Instr) and the decode stage.
//  Fetch pushes one {pc, instr} pair per cycle when there is space. Decode pops in order.
//  The queue decouples fetch from decode stalls. A redirect (branch/jump resolved) flushes it.
//  Output is first-word-fall-through: head entry is visible combinationally while out_valid=1.
// PARAMETERS
//  DEPTH   4   number of entries; power of two, >= 2
//  AW      2   pointer width = log2(DEPTH); count is AW+1 bits wide
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  rst        in   1      reset, synchronous, active-high
//  flush      in   1      discard all entries and any same-cycle push (redirect)
//  in_valid   in   1      fetch presents a valid {in_pc, in_instr}
//  in_ready   out  1      queue can accept a push this cycle
//  in_pc      in   32     byte address of the fetched instruction
//  in_instr   in   32     fetched instruction word
//  out_valid  out  1      head entry is valid
//  out_ready  in   1      decode consumes head this cycle
//  out_pc     out  32     head pc; 32'h0 when empty
//  out_instr  out  32     head instruction; 32'h0 (nop) when empty
//  out_pc4    out  32     out_pc + 4; 32'h4 when empty
//  count      out  AW+1   current occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset: rd_ptr=wr_ptr=0, count=0 -> out_valid=0, in_ready=1, out_pc=0, out_instr=0, out_pc4=4.
//    Storage array is not cleared.
//  - push = in_valid & in_ready; pop = out_valid & out_ready (both evaluated pre-edge).
//  - in_ready = (count != DEPTH). This is a registered-state function only, with no pop-through:
//    when full, a push is refused even if a pop happens in the same cycle.
//  - out_valid = (count != 0). No bypass: a pushed entry appears at the output the cycle after
//    the push edge. Latency push->visible = 1 cycle.
//  - Push: mem[wr_ptr] <= {in_pc, in_instr}; wr_ptr increments mod DEPTH (natural AW-bit wrap).
//  - Pop: rd_ptr increments mod DEPTH.
//  - count update:
//    push only -> +1; pop only -> -1; push & pop (count between 1 and DEPTH-1) -> unchanged,
//    both pointers advance.
//  - Push when empty together with out_ready=1: no pop (out_valid=0). The entry is held.
//  - Pop when empty, or push when full: ignored. No state change, no error.
//  - flush=1 at an edge: rd_ptr=wr_ptr=0, count=0. Any push or pop in that cycle is discarded.
//    Fetch must present the redirected PC from the next cycle.
//  - Priority: rst > flush > push/pop.
//  - Reset mid-operation: any entry count returns to the reset state in one edge.
//  - out_pc4 is a 32-bit add that wraps modulo 2^32. No other arithmetic on data.
//  - Data fields pass through unmodified. The queue does not decode or inspect instructions.
// STRUCTURE
//  - Shared include control/SignalDefs.v gains:
//    `NOP_INSTR (32'h0000_0000) and `FQ_ENTRY_W (64, {pc, instr} packing).
//  - One natural sub-module: sync_fifo_fwft
//    (generic WIDTH/DEPTH FWFT FIFO with flush, count, ready/valid).
//  - fetch_queue wraps sync_fifo_fwft, packs/unpacks {pc, instr}, and adds the empty-output
//    muxing and out_pc4.
// TESTING
//  1. Reset:
//     rst=1 for 2 cycles, then idle -> count=0, out_valid=0, in_ready=1, out_instr=0, out_pc4=4.
//  2. Fill/drain:
//     push pc=0x3000..0x300C (instr 0x24010001..4), out_ready=0 -> count=4, in_ready=0.
//     Fifth push refused. Then out_ready=1 -> pops 0x3000..0x300C in order, then out_valid=0.
//  3. Streaming:
//     continuous push with out_ready=1 from empty -> first out_valid one cycle after first push.
//     count then stays 1. Output pcs are consecutive with no gaps or duplicates.
//  4. Full plus simultaneous pop/push:
//     count=4, in_valid=1, out_ready=1 -> push refused, pop taken, count=3.
//     Next cycle push accepted.
//  5. Flush:
//     count=3, flush=1 with in_valid=1, pc=0x3040 -> next cycle count=0, out_valid=0.
//     Push pc=0x3080 -> it is the next entry popped.
//  6. Wrap and reset:
//     run 10 push/pop cycles so pointers wrap twice, checking order against a scoreboard.
//     Assert rst at count=2 -> next cycle count=0, out_valid=0.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package fetch_queue_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned FQ_ENTRY_W = 64;
    localparam word_t       NOP_INSTR  = 32'h0000_0000;

    // {pc, instr} packing: pc lives in the upper word.
    typedef struct packed {
        word_t pc;
        word_t instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side push and decode-side pop signals of the prefetch queue.
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
);
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    word_t       in_pc;
    word_t       in_instr;
    logic        out_valid;
    logic        out_ready;
    word_t       out_pc;
    word_t       out_instr;
    word_t       out_pc4;
    logic [AW:0] count;

    modport master (
        output flush, in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_pc4, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_pc4, count
    );

endinterface

// File: rtl/fetch_queue_sync_fifo_fwft.sv
// Generic first-word-fall-through FIFO with synchronous flush and occupancy count.
module fetch_queue_sync_fifo_fwft #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             push, pop;

    // No pop-through: readiness depends only on registered occupancy.
    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage is never cleared; stale slots are unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: packs {pc, instr} into a FWFT FIFO, zeroes outputs when empty.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input logic          clk,
    input logic          rst,
    fetch_queue_if.slave bus
);

    fq_entry_t in_entry;
    fq_entry_t head;

    assign in_entry = '{pc: bus.in_pc, instr: bus.in_instr};

    fetch_queue_sync_fifo_fwft #(
        .WIDTH (FQ_ENTRY_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_entry),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (head),
        .count     (bus.count)
    );

    assign bus.out_pc    = bus.out_valid ? head.pc    : 32'h0;
    assign bus.out_instr = bus.out_valid ? head.instr : NOP_INSTR;
    assign bus.out_pc4   = bus.out_pc + 32'd4;

endmodule
